seven_seg_scan_ctrl: RTL and testbench

Parametrised N-digit multiplexed 7-segment display controller and successor to the fixed two-digit display. It accepts a binary value and converts it to BCD with a sequential shift-add-3 (double-dabble) engine. It then scans the digits with leading-zero blanking, per-digit decimal points, PWM brightness control and overflow indication. It sits between datapath counters or registers and the board's anode/segment pins.

---
 rtl/seven_seg_scan_ctrl.sv | 163 ++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - N-digit multiplexed 7-segment controller with double-dabble BCD conversion
module seven_seg_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int WIDTH    = 14,
    parameter int DIV      = 12,
    parameter int BLANK_LZ = 1
) (
    input  logic              CLK,
    input  logic              CLR_N,
    input  logic [WIDTH-1:0]  VAL,
    input  logic              LOAD,
    input  logic [DIGITS-1:0] DP_EN,
    input  logic [3:0]        BRIGHT,
    output logic              BUSY,
    output logic              OVF,
    output logic [DIGITS-1:0] an,
    output logic [7:0]        seg
);

    localparam int BW = 4 * (DIGITS + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(WIDTH + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] LIMIT = pow10(DIGITS);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t              state, state_nx;
    logic [WIDTH-1:0]    bin_q;
    logic [BW-1:0]       bcd_q, bcd_adj;
    logic [CW-1:0]       cnt_q;
    logic                big_q;
    logic [4*DIGITS-1:0] disp_q;
    logic                ovf_q;
    logic [DIV-1:0]      presc_q;
    logic [IW-1:0]       idx_q;

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (LOAD) state_nx = S_SHIFT;
            S_SHIFT: if (cnt_q == CW'(WIDTH - 1)) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign BUSY = (state != S_IDLE);
    assign OVF  = ovf_q;

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < DIGITS + 1; i++)
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end

    // big_q also latches any carry shifted out of the BCD register, so oversized WIDTHs still flag overflow
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            big_q  <= 1'b0;
            disp_q <= '1;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (LOAD) begin
                    bin_q <= VAL;
                    bcd_q <= '0;
                    cnt_q <= '0;
                    big_q <= (64'(VAL) >= LIMIT);
                end
                S_SHIFT: begin
                    bcd_q <= {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
                    bin_q <= bin_q << 1;
                    cnt_q <= cnt_q + 1'b1;
                    big_q <= big_q | bcd_adj[BW-1];
                end
                S_DONE: begin
                    disp_q <= bcd_q[4*DIGITS-1:0];
                    ovf_q  <= big_q | (|bcd_q[BW-1:4*DIGITS]);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
            if (&presc_q) idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    logic              on;
    logic [3:0]        digit;
    logic              dp_sel, blank_sel, zero_above;
    logic [DIGITS-1:0] an_nx;
    logic [7:0]        seg_nx;
    logic [6:0]        pat;

    // Leading-zero test walks down from the top digit; the blank code 4'hF never counts as zero
    always_comb begin
        on         = (presc_q[DIV-1 -: 4] < BRIGHT);
        digit      = 4'hF;
        dp_sel     = 1'b0;
        blank_sel  = 1'b0;
        zero_above = 1'b1;
        an_nx      = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (disp_q[4*i +: 4] == 4'd0);
            if (idx_q == IW'(i)) begin
                digit     = disp_q[4*i +: 4];
                dp_sel    = DP_EN[i];
                blank_sel = zero_above && (i != 0) && (BLANK_LZ != 0);
            end
            an_nx[i] = !(on && (idx_q == IW'(i)));
        end
        case (digit)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = 7'h7F;
        endcase
        if (ovf_q)          pat = 7'b0111111;
        else if (blank_sel) pat = 7'h7F;
        seg_nx = on ? {~dp_sel, pat} : 8'hFF;
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            an  <= '1;
            seg <= 8'hFF;
        end else begin
            an  <= an_nx;
            seg <= seg_nx;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - randomized self-checking bench for seven_seg_scan_ctrl
module tb_seven_seg_scan_ctrl;

    logic        CLK = 1'b0;
    logic        CLR_N = 1'b0;
    logic [13:0] VAL = '0;
    logic        LOAD = 1'b0;
    logic [3:0]  DP_EN = '0;
    logic [3:0]  BRIGHT = 4'd15;
    logic        BUSY, OVF;
    logic [3:0]  an;
    logic [7:0]  seg;

    logic [9:0]  VAL2 = '0;
    logic        LOAD2 = 1'b0;
    logic [2:0]  DP_EN2 = '0;
    logic [3:0]  BRIGHT2 = 4'd15;
    logic        BUSY2, OVF2;
    logic [2:0]  an2;
    logic [7:0]  seg2;

    seven_seg_scan_ctrl #(.DIGITS(4), .WIDTH(14), .DIV(4), .BLANK_LZ(1)) dut (
        .CLK(CLK), .CLR_N(CLR_N), .VAL(VAL), .LOAD(LOAD), .DP_EN(DP_EN), .BRIGHT(BRIGHT),
        .BUSY(BUSY), .OVF(OVF), .an(an), .seg(seg));

    seven_seg_scan_ctrl #(.DIGITS(3), .WIDTH(10), .DIV(4), .BLANK_LZ(1)) dut3 (
        .CLK(CLK), .CLR_N(CLR_N), .VAL(VAL2), .LOAD(LOAD2), .DP_EN(DP_EN2), .BRIGHT(BRIGHT2),
        .BUSY(BUSY2), .OVF(OVF2), .an(an2), .seg(seg2));

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int k;
    int mval = 0, mval2 = 0;
    bit mvalid = 1'b0, mvalid2 = 1'b0;
    logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Clock edges seen since reset release: the free-running scan position is derived from this
    always @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) k <= 0;
        else        k <= k + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pw10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // Expected {an (padded to 8 bits with 1s), seg} for the scan position implied by edge count kk
    function automatic logic [15:0] exp_out(input int kk, input int nd, input int v, input bit valid,
                                            input logic [7:0] dp, input logic [3:0] br);
        int p, idx, pw;
        logic [7:0] a, s;
        logic [6:0] pat;
        if (kk == 0) return 16'hFFFF;
        p   = (kk - 1) % 16;
        idx = ((kk - 1) / 16) % nd;
        a = 8'hFF;
        s = 8'hFF;
        if (p < int'(br)) begin
            a[idx] = 1'b0;
            pw = pw10(idx);
            if (!valid)                      pat = 7'h7F;
            else if (v >= pw10(nd))          pat = 7'b0111111;
            else if (idx > 0 && v < pw)      pat = 7'h7F;
            else                             pat = segtab[(v / pw) % 10];
            s = {~dp[idx], pat};
        end
        return {a, s};
    endfunction

    task automatic scan_check(input int n);
        logic [15:0] e;
        repeat (n) begin
            @(negedge CLK);
            e = exp_out(k, 4, mval, mvalid, {4'h0, DP_EN}, BRIGHT);
            chk("an", {24'h0, 4'hF, an}, {24'h0, e[15:8]});
            chk("seg", {24'h0, seg}, {24'h0, e[7:0]});
        end
    endtask

    task automatic scan_check2(input int n);
        logic [15:0] e;
        repeat (n) begin
            @(negedge CLK);
            e = exp_out(k, 3, mval2, mvalid2, {5'h0, DP_EN2}, BRIGHT2);
            chk("an3", {24'h0, 5'h1F, an2}, {24'h0, e[15:8]});
            chk("seg3", {24'h0, seg2}, {24'h0, e[7:0]});
        end
    endtask

    // Load v, optionally pulse a second LOAD (junk value) at busy cycle ign, measure BUSY length
    task automatic load1(input int v, input int ign);
        int cnt;
        @(negedge CLK);
        VAL  = 14'(v);
        LOAD = 1'b1;
        @(negedge CLK);
        LOAD = 1'b0;
        cnt  = 0;
        while (BUSY && cnt < 100) begin
            cnt++;
            LOAD = (ign != 0 && cnt == ign);
            if (LOAD) VAL = 14'd1111;
            @(negedge CLK);
        end
        LOAD = 1'b0;
        chk("busy_len", cnt, 15);
        mval   = v;
        mvalid = 1'b1;
        chk("ovf", {31'h0, OVF}, {31'h0, (v >= 10000)});
        @(negedge CLK);
    endtask

    int vals   [6] = '{9999, 7, 0, 12345, 42, 10000};
    int brs    [6] = '{15, 15, 4, 15, 0, 9};
    int igns   [6] = '{0, 0, 0, 0, 3, 7};

    initial begin
        int cnt;
        repeat (3) @(negedge CLK);
        chk("rst_an", {28'h0, an}, 32'hF);
        chk("rst_seg", {24'h0, seg}, 32'hFF);
        chk("rst_busy", {31'h0, BUSY}, 32'h0);
        chk("rst_ovf", {31'h0, OVF}, 32'h0);
        CLR_N = 1'b1;
        scan_check(64);

        load1(42, 0);
        scan_check(64);

        // Abort a conversion of 1234 in its fifth shift cycle
        @(negedge CLK);
        VAL  = 14'd1234;
        LOAD = 1'b1;
        @(negedge CLK);
        LOAD = 1'b0;
        repeat (4) @(negedge CLK);
        #2 CLR_N = 1'b0;
        #1;
        chk("abort_an", {28'h0, an}, 32'hF);
        chk("abort_seg", {24'h0, seg}, 32'hFF);
        chk("abort_busy", {31'h0, BUSY}, 32'h0);
        @(negedge CLK);
        CLR_N  = 1'b1;
        mvalid = 1'b0;
        chk("abort_ovf", {31'h0, OVF}, 32'h0);
        scan_check(70);

        for (int i = 0; i < 10; i++) begin
            if (i < 6) begin
                BRIGHT = 4'(brs[i]);
                DP_EN  = (i == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                load1(vals[i], igns[i]);
            end else begin
                BRIGHT = 4'($urandom_range(0, 15));
                DP_EN  = 4'($urandom_range(0, 15));
                load1($urandom_range(0, 16383), $urandom_range(0, 12));
            end
            scan_check(64 + $urandom_range(0, 20));
        end

        // Three-digit instance: scan wraps 2 -> 0 and DP lights only on digit 1
        @(negedge CLK);
        VAL2   = 10'd305;
        DP_EN2 = 3'b010;
        LOAD2  = 1'b1;
        @(negedge CLK);
        LOAD2 = 1'b0;
        cnt   = 0;
        while (BUSY2 && cnt < 100) begin
            cnt++;
            @(negedge CLK);
        end
        chk("busy3_len", cnt, 11);
        chk("ovf3", {31'h0, OVF2}, 32'h0);
        mval2   = 305;
        mvalid2 = 1'b1;
        @(negedge CLK);
        scan_check2(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
